// File: rtl/divu_hilo_unit.sv
// divu_hilo_unit: multi-cycle unsigned restoring divider owning the HI/LO pair.
// A divu takes WIDTH iterations (one quotient bit per cycle). Later divu, mfhi
// or mflo instructions that reach EX while a division is in flight are held
// with a combinational stall until the DONE cycle.
module divu_hilo_unit #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  ALU_divu = 6'b011011,
    parameter logic [5:0]  ALU_mfhi = 6'b010000,
    parameter logic [5:0]  ALU_mflo = 6'b010010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [5:0]       ALUOperation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             stall,
    output logic             div_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // One restoring-division step. The partial remainder is shifted left with
    // the next dividend bit into a WIDTH+1-bit value and the divisor is trial
    // subtracted. Returns {new remainder, new quotient bit}. The kept
    // remainder is always below the divisor, so it fits in WIDTH bits.
    function automatic logic [WIDTH:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic             q_msb,
        input logic [WIDTH-1:0] dvsr
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        logic [WIDTH:0] res;
        shifted = {rem, q_msb};
        trial   = shifted - {1'b0, dvsr};
        if (trial[WIDTH] == 1'b0) begin
            res = {trial[WIDTH-1:0], 1'b1};
        end else begin
            res = {shifted[WIDTH-1:0], 1'b0};
        end
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             div_done_r;

    logic [WIDTH:0]   step_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quot_next_s;
    logic             is_divu_s;
    logic             is_mfhi_s;
    logic             is_mflo_s;
    logic             can_accept_s;
    logic             accept_s;
    logic             last_iter_s;

    // Datapath for the current iteration and operation decode.
    always_comb begin
        step_s       = div_step(rem_r, quot_r[WIDTH-1], divisor_r);
        rem_next_s   = step_s[WIDTH:1];
        quot_next_s  = {quot_r[WIDTH-2:0], step_s[0]};
        is_divu_s    = (ALUOperation == ALU_divu);
        is_mfhi_s    = (ALUOperation == ALU_mfhi);
        is_mflo_s    = (ALUOperation == ALU_mflo);
        can_accept_s = (state_r == S_IDLE) || (state_r == S_DONE);
        accept_s     = op_valid & is_divu_s & can_accept_s;
        last_iter_s  = (cnt_r == CW'(WIDTH - 1));
    end

    // Pipeline freeze while a division is in flight and EX needs the unit.
    always_comb begin
        if (op_valid && (state_r == S_BUSY) && (is_divu_s || is_mfhi_s || is_mflo_s)) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // HI/LO read mux; follows ALUOperation regardless of op_valid.
    always_comb begin
        if (is_mfhi_s) begin
            result = hi_r;
        end else if (is_mflo_s) begin
            result = lo_r;
        end else begin
            result = {WIDTH{1'b0}};
        end
    end

    // Division FSM, iteration registers and HI/LO; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            quot_r     <= {WIDTH{1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            div_done_r <= 1'b0;
        end else begin
            div_done_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        quot_r    <= a;
                        divisor_r <= b;
                        rem_r     <= {WIDTH{1'b0}};
                        cnt_r     <= {CW{1'b0}};
                        state_r   <= S_BUSY;
                    end else begin
                        state_r   <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    rem_r  <= rem_next_s;
                    quot_r <= quot_next_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_iter_s) begin
                        hi_r       <= rem_next_s;
                        lo_r       <= quot_next_s;
                        div_done_r <= 1'b1;
                        cnt_r      <= {CW{1'b0}};
                        state_r    <= S_DONE;
                    end else begin
                        state_r    <= S_BUSY;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign div_done = div_done_r;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Scoreboard bench for divu_hilo_unit: stimulus queues expected responses,
// a negedge monitor compares them as the DUT completes each operation.
module tb_divu_hilo_unit;

    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_MFHI = 6'b010000;
    localparam logic [5:0] OP_MFLO = 6'b010010;
    localparam logic [5:0] OP_ADDU = 6'b100001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [5:0]  alu_op = OP_ADDU;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] result;
    logic        stall;
    logic        div_done;
    logic [31:0] hi;
    logic [31:0] lo;

    divu_hilo_unit dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .ALUOperation (alu_op),
        .a            (a),
        .b            (b),
        .result       (result),
        .stall        (stall),
        .div_done     (div_done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] val;
        int          stl;
    } op_exp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          gap;
    } div_exp_t;

    op_exp_t  op_q[$];
    div_exp_t div_q[$];
    int       acc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit stim_done = 1'b0;

    int mon_cyc;
    int mon_stall;
    int mon_last_done;
    bit mon_rst_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_div(input logic [31:0] ehi, input logic [31:0] elo, input int gap);
        div_exp_t d;
        d.hi = ehi;
        d.lo = elo;
        d.gap = gap;
        div_q.push_back(d);
    endtask

    // Present one instruction in EX and hold it until it is not stalled.
    task automatic issue(input logic [5:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input int exp_stall, input logic [31:0] exp_val);
        op_exp_t e;
        if (op == OP_DIVU || op == OP_MFHI || op == OP_MFLO) begin
            e.op = op;
            e.val = exp_val;
            e.stl = exp_stall;
            op_q.push_back(e);
        end
        op_valid = 1'b1;
        alu_op = op;
        a = va;
        b = vb;
        @(negedge clk);
        for (int g = 0; g < 100 && stall === 1'b1; g++) @(negedge clk);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        alu_op = OP_ADDU;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus: directed vectors.
    initial begin
        rst = 1'b1;
        op_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
        begin
            op_exp_t e;
            e.op = OP_MFLO;
            e.val = 32'd0;
            e.stl = 0;
            op_q.push_back(e);
        end
        op_valid = 1'b1;
        alu_op = OP_MFLO;
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
        rst = 1'b0;
        op_valid = 1'b0;
        alu_op = OP_ADDU;

        issue(OP_MFHI, 32'd0, 32'd0, 0, 32'd0);

        // basic divide, with an unrelated op during BUSY
        expect_div(32'd2, 32'd14, 0);
        issue(OP_DIVU, 32'd100, 32'd7, 0, 32'd0);
        issue(OP_ADDU, 32'd1, 32'd2, 0, 32'd0);
        idle(32);
        issue(OP_MFLO, 32'd0, 32'd0, 0, 32'd14);
        issue(OP_MFHI, 32'd0, 32'd0, 0, 32'd2);

        // hazard: mfhi in C1 stalls 32 cycles
        expect_div(32'd10, 32'd30, 0);
        issue(OP_DIVU, 32'd1000, 32'd33, 0, 32'd0);
        issue(OP_MFHI, 32'd0, 32'd0, 32, 32'd10);
        issue(OP_MFLO, 32'd0, 32'd0, 0, 32'd30);

        // boundaries
        expect_div(32'hDEADBEEF, 32'hFFFFFFFF, 0);
        issue(OP_DIVU, 32'hDEADBEEF, 32'd0, 0, 32'd0);
        idle(33);
        expect_div(32'd0, 32'hFFFFFFFF, 0);
        issue(OP_DIVU, 32'hFFFFFFFF, 32'd1, 0, 32'd0);
        idle(33);
        expect_div(32'd5, 32'd0, 0);
        issue(OP_DIVU, 32'd5, 32'hFFFFFFFF, 0, 32'd0);
        idle(33);
        issue(OP_MFHI, 32'd0, 32'd0, 0, 32'd5);

        // back-to-back divides
        expect_div(32'd0, 32'd10, 0);
        expect_div(32'd1, 32'd2, 33);
        issue(OP_DIVU, 32'd50, 32'd5, 0, 32'd0);
        issue(OP_DIVU, 32'd9, 32'd4, 32, 32'd0);
        idle(33);
        issue(OP_MFLO, 32'd0, 32'd0, 0, 32'd2);
        issue(OP_MFHI, 32'd0, 32'd0, 0, 32'd1);

        // abort in iteration 10; a divu during reset is not accepted
        issue(OP_DIVU, 32'd1234, 32'd5, 0, 32'd0);
        idle(9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        alu_op = OP_DIVU;
        a = 32'd77;
        b = 32'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        op_valid = 1'b0;
        alu_op = OP_ADDU;
        issue(OP_MFHI, 32'd0, 32'd0, 0, 32'd0);
        issue(OP_MFLO, 32'd0, 32'd0, 0, 32'd0);
        expect_div(32'd2, 32'd3, 0);
        issue(OP_DIVU, 32'd20, 32'd6, 0, 32'd0);
        idle(33);
        issue(OP_MFLO, 32'd0, 32'd0, 0, 32'd3);
        idle(40);
        stim_done = 1'b1;
    end

    // Monitor: compares DUT behaviour against the queued expectations.
    initial begin
        mon_cyc = 0;
        mon_stall = 0;
        mon_last_done = 0;
        mon_rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (mon_cyc > 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL watchdog: got %0d cycles expected completion", mon_cyc);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
            if (rst) acc_q.delete();
            if (rst && mon_rst_prev) begin
                chk("reset_hi", hi, 32'd0);
                chk("reset_lo", lo, 32'd0);
                chk("reset_div_done", {31'd0, div_done}, 32'd0);
                chk("reset_stall", {31'd0, stall}, 32'd0);
            end
            mon_rst_prev = rst;

            if (op_valid && !(alu_op == OP_DIVU || alu_op == OP_MFHI || alu_op == OP_MFLO)) begin
                chk("other_op_stall", {31'd0, stall}, 32'd0);
            end else if (op_valid) begin
                if (stall) begin
                    mon_stall++;
                end else if (rst && alu_op == OP_DIVU) begin
                    mon_stall = 0;
                end else begin
                    if (op_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_op: got op 0x%02h expected none", alu_op);
                    end else begin
                        op_exp_t e;
                        e = op_q.pop_front();
                        chk("op_order", {26'd0, alu_op}, {26'd0, e.op});
                        chk("stall_cycles", 32'(mon_stall), 32'(e.stl));
                        if (e.op == OP_DIVU) begin
                            acc_q.push_back(mon_cyc);
                        end else begin
                            chk("read_result", result, e.val);
                        end
                    end
                    mon_stall = 0;
                end
            end

            if (div_done) begin
                if (div_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_div_done: got pulse at cycle %0d expected none", mon_cyc);
                end else begin
                    div_exp_t d;
                    d = div_q.pop_front();
                    chk("div_hi", hi, d.hi);
                    chk("div_lo", lo, d.lo);
                    if (acc_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL div_latency: got done with no accept expected an accept");
                    end else begin
                        int acc;
                        acc = acc_q.pop_front();
                        chk("div_latency", 32'(mon_cyc - acc), 32'd33);
                    end
                    if (d.gap != 0) chk("div_done_gap", 32'(mon_cyc - mon_last_done), 32'(d.gap));
                end
                mon_last_done = mon_cyc;
            end

            if (stim_done) begin
                chk("op_queue_empty", 32'(op_q.size()), 32'd0);
                chk("div_queue_empty", 32'(div_q.size()), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

endmodule
